// File: rtl/sdram_aref_ctrl.sv
// Auto-refresh sub-controller: periodic refresh request, then one burst of
// precharge-all followed by AREF_NUM auto-refresh commands once granted.
module sdram_aref_ctrl #(
    parameter int CNT_REF_MAX = 750,
    parameter int TRP_CLK     = 2,
    parameter int TRFC_CLK    = 7,
    parameter int AREF_NUM    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic        aref_end,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_bank,
    output logic [12:0] aref_addr
);

    localparam int RW = $clog2(CNT_REF_MAX);
    localparam int CW = $clog2((TRFC_CLK > TRP_CLK) ? TRFC_CLK : TRP_CLK) + 1;
    localparam int AW = $clog2(AREF_NUM + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PCH  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;

    typedef enum logic [2:0] {
        S_IDLE, S_PCH, S_TRP, S_AREF, S_TRFC, S_END
    } state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] cnt_ref;
    logic [CW-1:0] cnt_clk;
    logic [AW-1:0] aref_cnt;
    logic          ref_wrap;

    assign ref_wrap  = (cnt_ref == RW'(CNT_REF_MAX - 1));
    // A10 high makes the PRECHARGE a precharge-all
    assign aref_bank = 2'b11;
    assign aref_addr = 13'h1FFF;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || !init_end) cnt_ref <= '0;
        else if (ref_wrap)    cnt_ref <= '0;
        else                  cnt_ref <= cnt_ref + 1'b1;
    end

    // Request set beats the PCH acknowledge when both land on the same edge
    always_ff @(posedge clk) begin
        if (rst || !init_end)    aref_req <= 1'b0;
        else if (ref_wrap)       aref_req <= 1'b1;
        else if (state == S_PCH) aref_req <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst || state_nxt != state) cnt_clk <= '0;
        else                           cnt_clk <= cnt_clk + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE) aref_cnt <= '0;
        else if (state == S_AREF)   aref_cnt <= aref_cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (aref_en) state_nxt = S_PCH;
            S_PCH:  state_nxt = S_TRP;
            S_TRP:  if (cnt_clk == CW'(TRP_CLK - 1)) state_nxt = S_AREF;
            S_AREF: state_nxt = S_TRFC;
            S_TRFC: if (cnt_clk == CW'(TRFC_CLK - 1))
                        state_nxt = (aref_cnt == AW'(AREF_NUM)) ? S_END : S_AREF;
            S_END:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        aref_cmd = CMD_NOP;
        aref_end = 1'b0;
        case (state)
            S_PCH:   aref_cmd = CMD_PCH;
            S_AREF:  aref_cmd = CMD_AREF;
            S_END:   aref_end = 1'b1;
            default: aref_cmd = CMD_NOP;
        endcase
    end

endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// Directed bench for sdram_aref_ctrl: inputs driven and outputs sampled on
// the falling edge, expected values written out by hand.
module tb_sdram_aref_ctrl;

    localparam logic [3:0] NOP  = 4'b0111;
    localparam logic [3:0] PRE  = 4'b0010;
    localparam logic [3:0] REF  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst, init_end, aref_en;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_bank;
    logic [12:0] aref_addr;

    int checks = 0;
    int errors = 0;

    sdram_aref_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .init_end  (init_end),
        .aref_en   (aref_en),
        .aref_req  (aref_req),
        .aref_end  (aref_end),
        .aref_cmd  (aref_cmd),
        .aref_bank (aref_bank),
        .aref_addr (aref_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command expected p cycles after PRECHARGE within one burst
    function automatic logic [3:0] burst_cmd(input int p);
        if (p == 0) return PRE;
        if (p == 3 || p == 11) return REF;
        return NOP;
    endfunction

    // Falling edges until aref_req is seen high; also counts non-NOP commands
    task automatic wait_req(output int n, output int bad);
        n = 0;
        bad = 0;
        do begin
            @(negedge clk);
            n++;
            if (aref_cmd !== NOP) bad++;
        end while (!aref_req && n < 2000);
    endtask

    initial begin
        int n, bad;
        int cyc, rises, last_rise, refs, in_burst, last_pch, last_ref, viol;
        logic prev_req;

        // Reset, then init held off for 1000 cycles
        rst = 1'b1; init_end = 1'b0; aref_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd",  32'(aref_cmd),  32'(NOP));
        chk("rst_req",  32'(aref_req),  32'd0);
        chk("rst_end",  32'(aref_end),  32'd0);
        chk("rst_bank", 32'(aref_bank), 32'd3);
        chk("rst_addr", 32'(aref_addr), 32'h1FFF);
        rst = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (aref_cmd !== NOP || aref_req !== 1'b0 || aref_bank !== 2'b11 ||
                aref_addr !== 13'h1FFF) bad++;
        end
        chk("init_hold_bad_cycles", 32'(bad), 32'd0);

        // First request: 750 rising edges after init_end goes high
        init_end = 1'b1;
        wait_req(n, bad);
        chk("first_req_latency", 32'(n), 32'd750);
        chk("first_req_nop", 32'(bad), 32'd0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (aref_req !== 1'b1 || aref_cmd !== NOP) bad++;
        end
        chk("req_held_ungranted", 32'(bad), 32'd0);

        // Single granted burst, arbiter drops grant on aref_end
        aref_en = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("burst_cmd_%0d", c), 32'(aref_cmd), 32'(burst_cmd(c)));
            chk($sformatf("burst_end_%0d", c), 32'(aref_end), (c == 19) ? 32'd1 : 32'd0);
            chk($sformatf("burst_req_%0d", c), 32'(aref_req), (c == 0) ? 32'd1 : 32'd0);
            if (aref_end) aref_en = 1'b0;
        end
        @(negedge clk);
        chk("post_burst_cmd", 32'(aref_cmd), 32'(NOP));
        chk("post_burst_end", 32'(aref_end), 32'd0);

        // Periodicity with an arbiter model and a tRP/tRFC spacing monitor
        cyc = 0; rises = 0; last_rise = 0; refs = 0; in_burst = 0;
        last_pch = -100; last_ref = -100; viol = 0;
        prev_req = aref_req;
        while (rises < 9 && cyc < 9000) begin
            @(negedge clk);
            cyc++;
            if (aref_cmd === PRE) begin
                last_pch = cyc;
                in_burst = 0;
            end
            if (aref_cmd === REF) begin
                if (in_burst == 0 && cyc - last_pch < 3) viol++;
                if (in_burst != 0 && cyc - last_ref < 8) viol++;
                last_ref = cyc;
                in_burst++;
                refs++;
            end
            if (aref_req && !prev_req) begin
                if (rises > 0) begin
                    chk($sformatf("period_%0d", rises), 32'(cyc - last_rise), 32'd750);
                    chk($sformatf("refs_%0d", rises), 32'(refs), 32'd2);
                end
                rises++;
                last_rise = cyc;
                refs = 0;
            end
            prev_req = aref_req;
            if (aref_end) aref_en = 1'b0;
            else if (aref_req) aref_en = 1'b1;
        end
        chk("period_rises_seen", 32'(rises), 32'd9);
        chk("timing_violations", 32'(viol), 32'd0);

        // Reset during the first TRFC of a burst
        if (!aref_req) wait_req(n, bad);
        chk("mid_req_present", 32'(aref_req), 32'd1);
        aref_en = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (aref_cmd !== REF && n < 30);
        chk("mid_first_ref_at", 32'(n), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        aref_en = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd", 32'(aref_cmd), 32'(NOP));
        chk("mid_rst_req", 32'(aref_req), 32'd0);
        chk("mid_rst_end", 32'(aref_end), 32'd0);
        rst = 1'b0;
        wait_req(n, bad);
        chk("mid_rst_req_latency", 32'(n), 32'd750);
        chk("mid_rst_no_cmds", 32'(bad), 32'd0);

        // Stuck grant: bursts back-to-back, one IDLE cycle in between
        aref_en = 1'b1;
        for (int c = 0; c < 63; c++) begin
            @(negedge clk);
            chk($sformatf("stuck_cmd_%0d", c), 32'(aref_cmd),
                (c % 21 == 20) ? 32'(NOP) : 32'(burst_cmd(c % 21)));
            chk($sformatf("stuck_end_%0d", c), 32'(aref_end),
                (c % 21 == 19) ? 32'd1 : 32'd0);
        end
        aref_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
